tlb_lookup: RTL

- Fully associative Sv39 translation cache, directly upstream of the page-table walker.
- Accepts one virtual address at a time and returns its physical address.
- On a hit, returns the translation without a walk. On a miss, issues a walk request, waits for the walker result, refills one entry, then responds.
- One instance per port: instruction fetch and data access.

---
 rtl/tlb_lookup_if.sv | 22 ++
 rtl/tlb_lookup.sv | 103 ++++++++++
 2 files changed

// File: rtl/tlb_lookup_if.sv
// tlb_lookup_if: request/response and page-walker handshake bundle for tlb_lookup.
// master drives requests and walker results; slave is the TLB.
interface tlb_lookup_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_vaddr;
    logic        resp_valid;
    logic [63:0] resp_paddr;
    logic        walk_req;
    logic [63:0] walk_vaddr;
    logic        walk_done;
    logic [63:0] walk_paddr;
    logic [1:0]  walk_level;
    modport master (
        output req_valid, req_vaddr, walk_done, walk_paddr, walk_level,
        input  req_ready, resp_valid, resp_paddr, walk_req, walk_vaddr
    );
    modport slave (
        input  req_valid, req_vaddr, walk_done, walk_paddr, walk_level,
        output req_ready, resp_valid, resp_paddr, walk_req, walk_vaddr
    );
endinterface

// File: rtl/tlb_lookup.sv
// tlb_lookup: fully associative Sv39 TLB with superpage support, sitting in front of the page-table walker.
// Serves one request at a time: IDLE -> LOOKUP -> (WALK) -> RESP.
module tlb_lookup #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] satp,
    input  logic        sfence,
    tlb_lookup_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOOKUP, WALK, RESP} state_t;
    state_t             state, state_n;
    logic [63:0]        vaddr_q, resp_q, hit_pa;
    logic [19:0]        satp_q;
    logic [ENTRIES-1:0] valid, match;
    logic [26:0]        vpn_q [ENTRIES];
    logic [43:0]        ppn_q [ENTRIES];
    logic [1:0]         lvl_q [ENTRIES];
    logic [IDX_W-1:0]   repl_ptr, hit_idx, victim;
    logic [26:0]        vpn;
    logic [43:0]        hppn;
    logic [1:0]         hlvl;
    logic               hit, bare, flush, refill, stale, unused_ok;
    assign vpn            = vaddr_q[38:12];
    assign bare           = satp[63:60] == 4'd0;
    assign flush          = sfence || (satp[63:44] != satp_q);
    // a flush seen while this translation was in flight makes its walk result stale
    assign refill         = state == WALK && bus.walk_done && !flush && !stale;
    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.walk_req   = state == WALK;
    assign bus.walk_vaddr = vaddr_q;
    assign bus.resp_paddr = resp_q;
    assign unused_ok      = ^{satp[43:0], bus.walk_paddr[63:56]};
    genvar g;
    for (g = 0; g < ENTRIES; g++) begin : g_match
        assign match[g] = valid[g] && vpn_q[g][26:18] == vpn[26:18] &&
                          (lvl_q[g] == 2'd2 || vpn_q[g][17:9] == vpn[17:9]) &&
                          (lvl_q[g] != 2'd0 || vpn_q[g][8:0] == vpn[8:0]);
    end
    // descending scan so the lowest matching / lowest invalid index ends up selected
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        victim  = repl_ptr;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid[i]) victim = IDX_W'(i);
        end
    end
    assign hppn   = ppn_q[hit_idx];
    assign hlvl   = lvl_q[hit_idx];
    assign hit_pa = hlvl == 2'd2 ? {8'b0, hppn[43:18], vaddr_q[29:0]} :
                    hlvl == 2'd1 ? {8'b0, hppn[43:9], vaddr_q[20:0]} :
                                   {8'b0, hppn, vaddr_q[11:0]};
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.req_valid ? LOOKUP : IDLE;
            LOOKUP:  state_n = (bare || hit) ? RESP : WALK;
            WALK:    state_n = bus.walk_done ? RESP : WALK;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vaddr_q  <= '0;
            resp_q   <= '0;
            satp_q   <= '0;
            valid    <= '0;
            repl_ptr <= '0;
            stale    <= 1'b0;
        end else begin
            state  <= state_n;
            satp_q <= satp[63:44];
            stale  <= state == IDLE ? 1'b0 : stale | flush;
            if (state == IDLE && bus.req_valid) vaddr_q <= bus.req_vaddr;
            if (state == LOOKUP && bare) resp_q <= {8'b0, vaddr_q[55:0]};
            else if (state == LOOKUP && hit) resp_q <= hit_pa;
            else if (state == WALK && bus.walk_done) resp_q <= {8'b0, bus.walk_paddr[55:0]};
            if (flush) begin
                valid    <= '0;
                repl_ptr <= '0;
            end else if (refill) begin
                valid[victim] <= 1'b1;
                if (&valid) repl_ptr <= repl_ptr + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (refill) begin
            vpn_q[victim] <= vpn;
            ppn_q[victim] <= bus.walk_paddr[55:12];
            lvl_q[victim] <= bus.walk_level == 2'd3 ? 2'd0 : bus.walk_level;
        end
    end
endmodule
